taillight_sched: RTL
====================

TAILLIGHT_SCHED -- requirements
Module: taillight_sched

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 8, meaning clk cycles per lamp step (legal range 2..2^24).
REQ-002 The module SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The module SHALL have port reset  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 The module SHALL have port left_sw  input  1  left-turn request level.
REQ-005 The module SHALL have port right_sw  input  1  right-turn request level.
REQ-006 The module SHALL have port hazard_sw  input  1  hazard request level.
REQ-007 The module SHALL have port brake_sw  input  1  brake pedal level.
REQ-008 The module SHALL have port lamp_in  input  6  pattern from the lamp sequencer FSM, {LC,LB,LA,RA,RB,RC}.
REQ-009 The module SHALL have port l  output  1  left launch to the lamp FSM.
REQ-010 The module SHALL have port r  output  1  right launch to the lamp FSM.
REQ-011 The module SHALL have port step  output  1  clock enable for the lamp FSM state register.
REQ-012 The module SHALL have port busy  output  1  sequence in progress.
REQ-013 The module SHALL have port lamp_out  output  6  pattern driven to the lamps.

Function
REQ-014 The block SHALL run a prescaler counting 0..TICK_DIV-1, wrapping to 0, with internal tick high for exactly the one cycle where count == TICK_DIV-1.
REQ-015 The block SHALL hold sticky pending bits pl, pr, ph, each set in any cycle its switch is high and cleared only in the launch cycle that grants it.
REQ-016 The block SHALL implement states IDLE and RUN plus a 2-bit step counter sc.
REQ-017 Launch SHALL occur in a cycle with state==IDLE, tick==1 and any pending bit set; the block SHALL assert step=1 combinationally in that cycle, enter RUN, and set sc=1.
REQ-018 Launch grant SHALL be: ph set -> l=r=1 and clear ph, pl, pr; otherwise pl and pr both set -> the side selected by the round-robin bit, clearing only that bit; otherwise the single pending side.
REQ-019 The round-robin bit SHALL point to left after reset and SHALL toggle only after a left-versus-right contested grant.
REQ-020 In RUN, every tick SHALL assert step=1 and increment sc; on the tick where sc==3 the block SHALL return to IDLE, giving 4 steps per sequence (S0 -> first -> second -> third -> S0).
REQ-021 l and r SHALL be 0 in every cycle except the launch cycle; step SHALL be 0 when tick==0 and also in IDLE with no pending bit.
REQ-022 busy SHALL equal (state==RUN); requests arriving while busy SHALL only set pending bits and SHALL NOT alter the current sequence.
REQ-023 A switch held continuously SHALL re-launch on the first tick after the previous sequence ends (back-to-back, no idle tick).
REQ-024 lamp_out SHALL equal lamp_in except as given in REQ-029.

Reset
REQ-025 While reset==0 at a rising edge, the block SHALL clear the prescaler, pl, pr and ph, set state to IDLE, set sc=0 and point round-robin to left.
REQ-026 During and after reset, l=r=step=busy=0, and lamp_out SHALL equal lamp_in (all zeros once the lamp FSM is reset).
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no further step; the system SHALL reset the lamp FSM in the same cycle.

Configuration
REQ-028 Macro BRAKE_OVERRIDE_EN SHALL compile the brake override in or out.
REQ-029 With BRAKE_OVERRIDE_EN defined and brake_sw==1, each lamp side not part of the active or launching grant SHALL be forced to 3'b111 (both sides in IDLE; no effect during hazard); without the macro, brake_sw SHALL be ignored and lamp_out SHALL be lamp_in.

Verification (TICK_DIV=4)
REQ-030 Reset: hold reset=0 for 3 cycles with all switches high -> l=r=step=busy=0; after release the first launch occurs at prescaler count 3.
REQ-031 Single left: left_sw pulsed 1 cycle -> one launch with l=1,r=0, then steps at 4-cycle spacing, busy high for 12 cycles, 4 steps total.
REQ-032 Contention: left_sw and right_sw held high -> grants alternate L,R,L,R back-to-back; hazard_sw raised mid-sequence -> the next launch is l=r=1 and pl/pr are cleared.
REQ-033 Mid-sequence reset: reset=0 after the 2nd step -> no further step, busy=0, IDLE on release.
REQ-034 Brake override (macro on): brake_sw=1 with a left sequence running and lamp_in=6'b011000 -> lamp_out=6'b011111; brake_sw=1 in IDLE -> lamp_out=6'b111111; macro off -> lamp_out=lamp_in.

Source files
------------

// File: rtl/taillight_sched.sv
// taillight_sched: tick prescaler, sticky turn/hazard arbitration and step enables for the lamp sequencer.
// Define BRAKE_OVERRIDE_EN to force idle lamp sides to full-on while braking.
module taillight_sched #(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    input  logic       brake_sw,
    input  logic [5:0] lamp_in,
    output logic       l,
    output logic       r,
    output logic       step,
    output logic       busy,
    output logic [5:0] lamp_out
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sc_q, sc_d;
    logic [0:0]    state_q, state_d;
    logic          pl_q, pl_d, pr_q, pr_d, ph_q, ph_d, rr_q, rr_d;
    logic          tick, launch, contest, gnt_l, gnt_r, run_tick;
    always_comb begin
        tick     = cnt_q == CW'(TICK_DIV - 1);
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        launch   = reset && state_q == IDLE && tick && (pl_q || pr_q || ph_q);
        run_tick = reset && state_q == RUN && tick;
        contest  = pl_q && pr_q && !ph_q;
        // rr_q low means left wins the next contested grant
        gnt_l    = ph_q || (pl_q && (!pr_q || !rr_q));
        gnt_r    = ph_q || (pr_q && (!pl_q || rr_q));
        l        = launch && gnt_l;
        r        = launch && gnt_r;
        step     = launch || run_tick;
        busy     = reset && state_q == RUN;
        pl_d     = (pl_q && !l) || left_sw;
        pr_d     = (pr_q && !r) || right_sw;
        ph_d     = (ph_q && !launch) || hazard_sw;
        rr_d     = rr_q ^ (launch && contest);
        state_d  = launch ? RUN : (run_tick && sc_q == 2'd3) ? IDLE : state_q;
        sc_d     = launch ? 2'd1 : run_tick ? sc_q + 2'd1 : sc_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            sc_q    <= 2'd0;
            state_q <= IDLE;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            ph_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            state_q <= state_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            ph_q    <= ph_d;
            rr_q    <= rr_d;
        end
    end
`ifdef BRAKE_OVERRIDE_EN
    logic gl_q, gl_d, gr_q, gr_d, force_l, force_r;
    always_comb begin
        gl_d     = launch ? gnt_l : gl_q;
        gr_d     = launch ? gnt_r : gr_q;
        // a side owned by the running or launching grant keeps its pattern
        force_l  = reset && brake_sw && !(l || (busy && gl_q));
        force_r  = reset && brake_sw && !(r || (busy && gr_q));
        lamp_out = {force_l ? 3'b111 : lamp_in[5:3], force_r ? 3'b111 : lamp_in[2:0]};
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            gl_q <= 1'b0;
            gr_q <= 1'b0;
        end else begin
            gl_q <= gl_d;
            gr_q <= gr_d;
        end
    end
`else
    logic unused_brake;
    assign unused_brake = brake_sw;
    assign lamp_out     = lamp_in;
`endif
endmodule
